// File: rtl/ram_port_arbiter_if.sv
// Request/grant bundle between the output RAM, the CPU and the readout engine.
// The slave view belongs to the arbiter; the master view to the requesters and the RAM.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;

  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  rd_req, rd_addr,
    output rd_gnt, rd_rvalid, rd_rdata,
    output ram_ena, ram_wea, ram_addra, ram_dina,
    input  ram_douta
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output rd_req, rd_addr,
    input  rd_gnt, rd_rvalid, rd_rdata,
    input  ram_ena, ram_wea, ram_addra, ram_dina,
    output ram_douta
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Per-cycle arbiter for the single-port output RAM: CPU has priority, the readout
// wins once it has been denied STARVE_LIM consecutive cycles.
module ram_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 3
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus,
  output logic [1:0]          owner
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_RD   = 2'b10
  } owner_e;

  owner_e            owner_q;
  owner_e            owner_d;
  logic [3:0]        wait_cnt;
  logic [1:0]        rsel_p1;
  logic              starved_p0;
  logic              cpu_gnt_p0;
  logic              rd_gnt_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] din_p0;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  // Stage p0: combinational grant and RAM mux, forced idle while reset is held.
  always_comb begin
    cpu_gnt_p0 = 1'b0;
    rd_gnt_p0  = 1'b0;
    starved_p0 = bus.rd_req && (wait_cnt == LIM);
    if (reset) begin
      if (starved_p0)
        rd_gnt_p0 = 1'b1;
      else if (bus.cpu_req)
        cpu_gnt_p0 = 1'b1;
      else if (bus.rd_req)
        rd_gnt_p0 = 1'b1;
    end
  end

  always_comb begin
    addr_p0 = '0;
    din_p0  = '0;
    if (cpu_gnt_p0) begin
      addr_p0 = bus.cpu_addr;
      din_p0  = bus.cpu_wdata;
    end else if (rd_gnt_p0) begin
      addr_p0 = bus.rd_addr;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_p0;
  assign bus.rd_gnt    = rd_gnt_p0;
  assign bus.ram_ena   = cpu_gnt_p0 | rd_gnt_p0;
  assign bus.ram_wea   = cpu_gnt_p0 & bus.cpu_we;
  assign bus.ram_addra = addr_p0;
  assign bus.ram_dina  = din_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      rsel_p1  <= 2'b00;
    end else begin
      rsel_p1 <= {cpu_gnt_p0 & ~bus.cpu_we, rd_gnt_p0};
      if (bus.rd_req && !rd_gnt_p0)
        wait_cnt <= sat_inc(wait_cnt, LIM);
      else
        wait_cnt <= 4'd0;
    end
  end

  // Stage p1: RAM data returns one cycle after the grant and is steered by rsel.
  assign bus.cpu_rvalid = rsel_p1[1];
  assign bus.rd_rvalid  = rsel_p1[0];
  assign bus.cpu_rdata  = rsel_p1[1] ? bus.ram_douta : '0;
  assign bus.rd_rdata   = rsel_p1[0] ? bus.ram_douta : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      owner_q <= OWN_NONE;
    else
      owner_q <= owner_d;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt_p0)
      owner_d = OWN_CPU;
    else if (rd_gnt_p0)
      owner_d = OWN_RD;
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a rule-level model of grants,
// wait counting and read returns, driven by directed and random steps.
module tb_ram_port_arbiter;

  localparam int LIM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] owner;

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .owner (owner)
  );

  always #5 clk = ~clk;

  // Behavioural single-port block RAM with one cycle read latency.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_ena) begin
      if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
      bus.ram_douta <= mem[bus.ram_addra];
    end
  end

  // Reference model state
  logic [15:0] shadow [64];
  int          m_wait = 0;
  bit          m_cpu_pend = 0;
  bit          m_rd_pend = 0;
  logic [15:0] m_cpu_val = '0;
  logic [15:0] m_rd_val = '0;
  logic [1:0]  m_owner = 2'b00;
  logic        last_rd_gnt;
  logic [11:0] pattern;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit drop_reset = 1'b0);
    logic        starved, e_cpu, e_rd;
    logic [5:0]  e_addr;
    logic [15:0] e_din;
    @(negedge clk);
    starved = bus.rd_req && (m_wait >= LIM);
    e_rd    = reset && bus.rd_req && (starved || !bus.cpu_req);
    e_cpu   = reset && bus.cpu_req && !e_rd;
    e_addr  = e_cpu ? bus.cpu_addr : (e_rd ? bus.rd_addr : 6'd0);
    e_din   = e_cpu ? bus.cpu_wdata : 16'd0;
    check("cpu_gnt",    32'(bus.cpu_gnt),    32'(e_cpu));
    check("rd_gnt",     32'(bus.rd_gnt),     32'(e_rd));
    check("gnt_excl",   32'(bus.cpu_gnt & bus.rd_gnt), 32'd0);
    check("ram_ena",    32'(bus.ram_ena),    32'(e_cpu | e_rd));
    check("ram_wea",    32'(bus.ram_wea),    32'(e_cpu & bus.cpu_we));
    check("ram_addra",  32'(bus.ram_addra),  32'(e_addr));
    check("ram_dina",   32'(bus.ram_dina),   32'(e_din));
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_cpu_pend));
    check("cpu_rdata",  32'(bus.cpu_rdata),  32'(m_cpu_pend ? m_cpu_val : 16'd0));
    check("rd_rvalid",  32'(bus.rd_rvalid),  32'(m_rd_pend));
    check("rd_rdata",   32'(bus.rd_rdata),   32'(m_rd_pend ? m_rd_val : 16'd0));
    check("owner",      32'(owner),          32'(m_owner));
    last_rd_gnt = bus.rd_gnt;
    if (drop_reset) begin
      reset = 1'b0;
      #1;
      check("rst_mid_rvalid", 32'(bus.rd_rvalid), 32'd0);
      check("rst_mid_gnt",    32'(bus.rd_gnt),    32'd0);
    end
    @(posedge clk);
    if (!reset) begin
      m_wait = 0; m_cpu_pend = 0; m_rd_pend = 0; m_owner = 2'b00;
    end else begin
      m_cpu_pend = e_cpu && !bus.cpu_we;
      m_rd_pend  = e_rd;
      if (m_cpu_pend) m_cpu_val = shadow[bus.cpu_addr];
      if (e_rd) m_rd_val = shadow[bus.rd_addr];
      if (e_cpu && bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
      if (bus.rd_req && !e_rd) m_wait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
      else m_wait = 0;
      m_owner = e_cpu ? 2'b01 : (e_rd ? 2'b10 : 2'b00);
    end
    #1;
  endtask

  initial begin
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 6'd0; bus.cpu_wdata = 16'h0000;
    bus.rd_req = 1'b1;  bus.rd_addr = 6'd0;

    // Reset held with both requests high, then release.
    cycle(); cycle();
    reset = 1'b1;
    #1;
    check("release_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    cycle();
    bus.rd_req = 1'b0;

    // Fill RAM through the CPU.
    for (int a = 0; a < 64; a++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
      bus.cpu_addr = 6'(a); bus.cpu_wdata = 16'($urandom);
      cycle();
    end

    // CPU write 0xBEEF to 5, then read it back.
    bus.cpu_addr = 6'd5; bus.cpu_wdata = 16'hBEEF; bus.cpu_we = 1'b1;
    cycle();
    bus.cpu_we = 1'b0;
    #1;
    check("read_no_wea", 32'(bus.ram_wea), 32'd0);
    cycle();
    bus.cpu_req = 1'b0;
    check("beef_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("beef_rdata",  32'(bus.cpu_rdata),  32'h0000BEEF);
    check("beef_no_rd",  32'(bus.rd_rvalid),  32'd0);
    cycle();

    // Readout-only sweep.
    for (int a = 0; a < 64; a++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 6'(a);
      cycle();
    end
    bus.rd_req = 1'b0;
    cycle();

    // Contention: both held for 12 cycles.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 6'd7;
    bus.rd_req = 1'b1;  bus.rd_addr = 6'd12;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pattern[i] = last_rd_gnt;
      check("wait_max", 32'(dut.wait_cnt <= 4'd3), 32'd1);
    end
    check("starve_pattern", 32'(pattern), 32'h888);
    bus.cpu_req = 1'b0; bus.rd_req = 1'b0;
    cycle();

    // Same-address write and read: CPU first, readout sees new data.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 6'd9; bus.cpu_wdata = 16'h0001;
    cycle();
    bus.cpu_req = 1'b0;
    cycle();
    bus.cpu_req = 1'b1; bus.cpu_wdata = 16'h00AA;
    bus.rd_req = 1'b1;  bus.rd_addr = 6'd9;
    cycle();
    bus.cpu_req = 1'b0;
    cycle();
    bus.rd_req = 1'b0;
    check("same_addr_rvalid", 32'(bus.rd_rvalid), 32'd1);
    check("same_addr_rdata",  32'(bus.rd_rdata),  32'h000000AA);
    cycle();

    // Reset asserted mid-read.
    bus.rd_req = 1'b1; bus.rd_addr = 6'd3;
    cycle(1'b1);
    bus.rd_req = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    check("post_rst_rvalid", 32'(bus.rd_rvalid), 32'd0);
    cycle();
    check("post_rst_rvalid2", 32'(bus.rd_rvalid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.cpu_req   = 1'($urandom_range(0, 1));
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 6'($urandom_range(0, 63));
      bus.cpu_wdata = 16'($urandom);
      bus.rd_req    = 1'($urandom_range(0, 1));
      bus.rd_addr   = 6'($urandom_range(0, 63));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
